// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin skid arbiter.
// Holds the egress buffer state encoding and the default sizing constants.
package rr_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/rr_grant_sel.sv
// Rotating-priority encoder: picks the first valid requester at or after rr_ptr_i.
// Purely combinational; any_valid_o flags that a grant exists.
module rr_grant_sel #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [SRC_W-1:0]   rr_ptr_i,
    output logic [SRC_W-1:0]   grant_o,
    output logic               any_valid_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[idx]) begin
                grant_o     = SRC_W'(idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_skid_arbiter.sv
// Round-robin arbiter feeding a registered two-entry (main + skid) egress stage.
// Optional packet locking is enabled by defining ARB_LOCK_EN (adds req_last_i).
module rr_skid_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_last_i,
`endif
    input  logic                      e_ready_i,
    output logic                      e_valid_o,
    output logic [DATA_W-1:0]         e_data_o,
    output logic [SRC_W-1:0]          e_src_o
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [SRC_W-1:0]  main_src_q, main_src_d, skid_src_q, skid_src_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              in_ready_q, in_ready_d;

    logic [SRC_W-1:0]  rr_grant, grant, grant_inc;
    logic              rr_any, grant_vld, accept, out_fire;
    logic [DATA_W-1:0] grant_data;

    rr_grant_sel #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_grant_sel (
        .req_valid_i (req_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (rr_grant),
        .any_valid_o (rr_any)
    );

`ifdef ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [SRC_W-1:0] lock_src_q, lock_src_d;

    // A locked packet owner is the only candidate; a stalled owner blocks everyone.
    assign grant     = lock_q ? lock_src_q : rr_grant;
    assign grant_vld = lock_q ? req_valid_i[lock_src_q] : rr_any;
`else
    assign grant     = rr_grant;
    assign grant_vld = rr_any;
`endif

    assign accept     = grant_vld & in_ready_q;
    assign out_fire   = e_valid_o & e_ready_i;
    assign grant_data = req_data_i[int'(grant)*DATA_W +: DATA_W];
    assign grant_inc  = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (in_ready_q && grant_vld) req_ready_o[grant] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_LOCK_EN
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (accept) begin
            if (req_last_i[grant]) begin
                lock_d   = 1'b0;
                rr_ptr_d = grant_inc;
            end else begin
                lock_d     = 1'b1;
                lock_src_d = grant;
            end
        end
`else
        if (accept) rr_ptr_d = grant_inc;
`endif
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_src_d  = main_src_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = grant_data;
                    main_src_d  = grant;
                    state_d     = HALF;
                end
            end
            HALF: begin
                if (accept && out_fire) begin
                    main_data_d = grant_data;
                    main_src_d  = grant;
                end else if (accept) begin
                    // Egress stalled: park the beat and close ingress for next cycle.
                    skid_data_d = grant_data;
                    skid_src_d  = grant;
                    state_d     = FULL;
                    in_ready_d  = 1'b0;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_src_d  = skid_src_q;
                    state_d     = HALF;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d    = EMPTY;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_src_q  <= '0;
            skid_data_q <= '0;
            skid_src_q  <= '0;
            rr_ptr_q    <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_src_q  <= main_src_d;
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            rr_ptr_q    <= rr_ptr_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            lock_src_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end
`endif

    assign e_valid_o = (state_q != EMPTY);
    assign e_data_o  = main_data_q;
    assign e_src_o   = main_src_q;

endmodule

// File: tb/tb_rr_skid_arbiter.sv
// Bench for rr_skid_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected beat sequences.
module tb_rr_skid_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NR-1:0]  req_valid_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]  req_ready_o;
    logic [NR-1:0]  req_last_i;
    logic           e_ready_i;
    logic           e_valid_o;
    logic [DW-1:0]  e_data_o;
    logic [SW-1:0]  e_src_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_skid_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
`ifdef ARB_LOCK_EN
        .req_last_i  (req_last_i),
`endif
        .e_ready_i   (e_ready_i),
        .e_valid_o   (e_valid_o),
        .e_data_o    (e_data_o),
        .e_src_o     (e_src_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats and a rotating pointer.
    int m_src[$];
    int m_dat[$];
    int m_ptr = 0;
    bit m_lock = 0;
    int m_owner = 0;

    // Observed egress beats and grants, for the directed literal checks.
    int log_src[$];
    int log_dat[$];
    int gnt_log[$];

    always @(negedge clk) begin
        int g;
        logic [NR-1:0] exp_rdy;
        if (!reset_n) begin
            m_src.delete();
            m_dat.delete();
            m_ptr  = 0;
            m_lock = 0;
            chk("rst_ready", 32'(req_ready_o), 0);
            chk("rst_valid", 32'(e_valid_o), 0);
            chk("rst_data", 32'(e_data_o), 0);
            chk("rst_src", 32'(e_src_o), 0);
        end else begin
            g = -1;
            if (m_src.size() < 2) begin
                if (m_lock) begin
                    if (req_valid_i[m_owner]) g = m_owner;
                end else begin
                    for (int i = NR - 1; i >= 0; i--)
                        if (req_valid_i[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("model_ready", 32'(req_ready_o), 32'(exp_rdy));
            chk("model_valid", 32'(e_valid_o), 32'(m_src.size() > 0));
            if (m_src.size() > 0) begin
                chk("model_src", 32'(e_src_o), 32'(m_src[0]));
                chk("model_data", 32'(e_data_o), 32'(m_dat[0]));
            end
            if (e_valid_o && e_ready_i) begin
                log_src.push_back(int'(e_src_o));
                log_dat.push_back(int'(e_data_o));
            end
            for (int k = 0; k < NR; k++)
                if (req_ready_o[k] && req_valid_i[k]) gnt_log.push_back(k);
            if (m_src.size() > 0 && e_ready_i) begin
                void'(m_src.pop_front());
                void'(m_dat.pop_front());
            end
            if (g >= 0) begin
                m_src.push_back(g);
                m_dat.push_back(int'(req_data_i[g*DW +: DW]));
`ifdef ARB_LOCK_EN
                if (req_last_i[g]) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % NR;
                end else begin
                    m_lock  = 1;
                    m_owner = g;
                end
`else
                m_ptr = (g + 1) % NR;
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_src.delete();
        log_dat.delete();
        gnt_log.delete();
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '1;
        e_ready_i   = 1'b0;
        step(2);
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic set_req(input int k, input logic v, input logic [DW-1:0] d);
        req_valid_i[k]          = v;
        req_data_i[k*DW +: DW]  = d;
    endtask

    task automatic chk_beat(input string name, input int i, input int src, input int dat);
        chk({name, "_have"}, 32'(log_src.size() > i), 1);
        if (log_src.size() > i) begin
            chk({name, "_src"}, 32'(log_src[i]), 32'(src));
            chk({name, "_data"}, 32'(log_dat[i]), 32'(dat));
        end
    endtask

    initial begin
        int gexp[4];
        int n1;
        int viol;
        bit acc1;
        reset_n     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '1;
        e_ready_i   = 1'b0;
        #1;
        do_reset();

        // Idle after reset: nothing granted, nothing emitted.
        for (int c = 0; c < 5; c++) begin
            chk("idle_valid", 32'(e_valid_o), 0);
            chk("idle_ready", 32'(req_ready_o), 0);
            chk("idle_src", 32'(e_src_o), 0);
            step(1);
        end

        // Requesters 0 and 2 alternate at full rate.
        e_ready_i = 1'b1;
        set_req(0, 1'b1, 8'hA0);
        set_req(2, 1'b1, 8'hC0);
        step(1);
        chk("alt_lat_valid", 32'(e_valid_o), 1);
        chk("alt_lat_src", 32'(e_src_o), 0);
        step(6);
        chk_beat("alt0", 0, 0, 'hA0);
        chk_beat("alt1", 1, 2, 'hC0);
        chk_beat("alt2", 2, 0, 'hA0);
        chk_beat("alt3", 3, 2, 'hC0);

        // Egress stall fills main + skid, then drains in acceptance order.
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 8'(8'h10 + k));
        e_ready_i = 1'b0;
        step(4);
        chk("stall_accepts", 32'(gnt_log.size()), 2);
        chk("stall_ready", 32'(req_ready_o), 0);
        chk("stall_valid", 32'(e_valid_o), 1);
        chk("stall_data", 32'(e_data_o), 'h10);
        chk("stall_src", 32'(e_src_o), 0);
        e_ready_i = 1'b1;
        step(8);
        for (int i = 0; i < 4; i++) chk_beat("drain", i, i, 'h10 + i);
        req_valid_i = '0;
        step(3);

        // Pointer wrap: grant 2 (ptr->3), then 3 alone, then 0 and 3 together.
        do_reset();
        e_ready_i = 1'b1;
        set_req(2, 1'b1, 8'h22);
        step(1);
        req_valid_i = '0;
        set_req(3, 1'b1, 8'h33);
        step(1);
        set_req(0, 1'b1, 8'h0F);
        step(2);
        req_valid_i = '0;
        step(2);
        gexp = '{2, 3, 0, 3};
        chk("wrap_cnt", 32'(gnt_log.size()), 4);
        for (int i = 0; i < 4; i++)
            if (gnt_log.size() > i) chk("wrap_grant", 32'(gnt_log[i]), 32'(gexp[i]));

        // Asynchronous reset while FULL drops both buffered beats.
        do_reset();
        set_req(0, 1'b1, 8'hE0);
        set_req(1, 1'b1, 8'hE1);
        e_ready_i = 1'b0;
        step(3);
        chk("full_valid", 32'(e_valid_o), 1);
        chk("full_ready", 32'(req_ready_o), 0);
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(e_valid_o), 0);
        req_valid_i = '0;
        e_ready_i   = 1'b1;
        step(2);
        reset_n = 1'b1;
        clear_logs();
        step(1);
        chk("post_rst_valid", 32'(e_valid_o), 0);
        set_req(1, 1'b1, 8'h55);
        step(1);
        req_valid_i = '0;
        step(3);
        chk("post_rst_cnt", 32'(log_src.size()), 1);
        chk_beat("post_rst", 0, 1, 'h55);

`ifdef ARB_LOCK_EN
        // Requester 1 holds the channel for a three-beat packet.
        do_reset();
        e_ready_i = 1'b1;
        n1   = 0;
        viol = 0;
        req_last_i = '1;
        set_req(1, 1'b1, 8'h11);
        req_last_i[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc1 = req_valid_i[1] & req_ready_o[1];
            if (n1 < 3 && c > 0 && req_ready_o[0]) viol++;
            @(posedge clk);
            #1;
            if (acc1) n1++;
            set_req(1, n1 < 3, 8'(8'h11 + n1));
            req_last_i[1] = (n1 == 2);
            set_req(0, 1'b1, 8'hA0);
        end
        req_valid_i = '0;
        step(2);
        chk("lock_r0_blocked", 32'(viol), 0);
        chk_beat("lock0", 0, 1, 'h11);
        chk_beat("lock1", 1, 1, 'h12);
        chk_beat("lock2", 2, 1, 'h13);
        chk_beat("lock3", 3, 0, 'hA0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
